// File: rtl/sdram_scheduler_if.sv
// Client/controller bundle of the sdram_scheduler.
// master = scheduler side, slave = clients and sdram_interface.
interface sdram_scheduler_if;
  logic        WR_REQ;
  logic [15:0] WR_DATA;
  logic        WR_ACK;
  logic        WR_DROP;
  logic        RD_REQ;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        FULL;
  logic        EMPTY;
  logic        OVERFLOW;
  logic        ERR_TIMEOUT;
  logic        READY;
  logic [1:0]  CMD_OUT;
  logic [1:0]  A_OUT_BANK;
  logic [12:0] A_OUT_ROW;
  logic [8:0]  A_OUT_COL;
  logic [15:0] D_OUT;
  logic        SDRAM_STATUS;
  logic [15:0] SDRAM_DATA_IN;

  modport master (
    input  WR_REQ, WR_DATA, RD_REQ,
    input  SDRAM_STATUS, SDRAM_DATA_IN,
    output WR_ACK, WR_DROP,
    output RD_DATA, RD_VALID,
    output FULL, EMPTY, OVERFLOW,
    output ERR_TIMEOUT, READY,
    output CMD_OUT, A_OUT_BANK,
    output A_OUT_ROW, A_OUT_COL, D_OUT
  );

  modport slave (
    output WR_REQ, WR_DATA, RD_REQ,
    output SDRAM_STATUS, SDRAM_DATA_IN,
    input  WR_ACK, WR_DROP,
    input  RD_DATA, RD_VALID,
    input  FULL, EMPTY, OVERFLOW,
    input  ERR_TIMEOUT, READY,
    input  CMD_OUT, A_OUT_BANK,
    input  A_OUT_ROW, A_OUT_COL, D_OUT
  );
endinterface

// File: rtl/sdram_scheduler.sv
// Shares one SDRAM command port between a logger writer
// and a telemetry reader over a circular buffer.
module sdram_scheduler #(
  parameter int DEPTH_WORDS   = 16777216,
  parameter int START_TIMEOUT = 16,
  parameter int INIT_IDLE     = 2
) (
  input logic               CLK_48MHZ,
  input logic               RESET,
  sdram_scheduler_if.master bus
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int IW = $clog2(INIT_IDLE + 1);
  localparam logic [24:0] DEPTH_C =
    25'(DEPTH_WORDS);
  localparam logic [23:0] PTR_LAST =
    24'(DEPTH_WORDS - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(START_TIMEOUT - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'(INIT_IDLE - 1);
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [23:0]   wr_ptr;
  logic [23:0]   rd_ptr;
  logic [24:0]   count;
  logic [24:0]   count_d;
  logic [23:0]   addr;
  logic [15:0]   d_out;
  logic [15:0]   rd_data;
  logic [1:0]    cmd;
  logic          wr_ack;
  logic          wr_drop;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          err_timeout;
  logic          ready;
  logic          last_wr;
  logic [TW-1:0] timer;
  logic [IW-1:0] init_cnt;

  logic pulse;
  logic cand_w;
  logic cand_r;
  logic grant_w;
  logic grant_r;
  logic drop;
  logic done;
  logic tout;

  function automatic logic [23:0] ptr_inc(
    input logic [23:0] p
  );
    return (p == PTR_LAST) ? 24'd0 : p + 24'd1;
  endfunction

  // an ack/valid cycle is never a grant cycle, so a
  // requester still holding its line is not re-served
  assign pulse  = wr_ack | rd_valid;
  assign cand_w = bus.WR_REQ;
  assign cand_r = bus.RD_REQ && !empty;

  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) state <= S_INIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant_w = 1'b0;
    grant_r = 1'b0;
    drop    = 1'b0;
    done    = 1'b0;
    tout    = 1'b0;
    unique case (state)
      S_INIT: begin
        if (!bus.SDRAM_STATUS && init_cnt == I_LAST)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!pulse) begin
          grant_w = cand_w && (!cand_r || !last_wr);
          grant_r = cand_r && !grant_w;
        end
        drop = grant_w && full;
        if ((grant_w && !full) || grant_r)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.SDRAM_STATUS) begin
          state_d = S_BUSY;
        end else if (timer == T_LAST) begin
          tout    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!bus.SDRAM_STATUS) begin
          done    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    count_d = count;
    if (done && last_wr)
      count_d = count + 25'd1;
    else if (done)
      count_d = count - 25'd1;
  end

  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr        <= '0;
      d_out       <= '0;
      rd_data     <= '0;
      cmd         <= CMD_IDLE;
      wr_ack      <= 1'b0;
      wr_drop     <= 1'b0;
      rd_valid    <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      err_timeout <= 1'b0;
      ready       <= 1'b0;
      last_wr     <= 1'b0;
      timer       <= '0;
      init_cnt    <= '0;
    end else begin
      wr_ack   <= 1'b0;
      wr_drop  <= 1'b0;
      rd_valid <= 1'b0;
      count    <= count_d;
      full     <= (count_d == DEPTH_C);
      empty    <= (count_d == 25'd0);
      if (state == S_INIT)
        init_cnt <= bus.SDRAM_STATUS ? '0
                  : init_cnt + IW'(1);
      if (state == S_INIT && state_d == S_IDLE)
        ready <= 1'b1;
      if (grant_w || grant_r) begin
        last_wr <= grant_w;
        addr    <= grant_w ? wr_ptr : rd_ptr;
        timer   <= '0;
      end
      if (grant_w)
        d_out <= bus.WR_DATA;
      if (drop) begin
        wr_ack   <= 1'b1;
        wr_drop  <= 1'b1;
        overflow <= 1'b1;
      end
      if (grant_w && !full)
        cmd <= CMD_WR;
      else if (grant_r)
        cmd <= CMD_RD;
      else if (state == S_ISSUE && state_d != S_ISSUE)
        cmd <= CMD_IDLE;
      if (state == S_ISSUE)
        timer <= timer + TW'(1);
      // a stalled controller still completes the request
      if (tout) begin
        err_timeout <= 1'b1;
        if (last_wr) wr_ack   <= 1'b1;
        else         rd_valid <= 1'b1;
      end
      if (done && last_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
        wr_ack <= 1'b1;
      end
      if (done && !last_wr) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        rd_data  <= bus.SDRAM_DATA_IN;
        rd_valid <= 1'b1;
      end
    end
  end

  assign bus.WR_ACK      = wr_ack;
  assign bus.WR_DROP     = wr_drop;
  assign bus.RD_DATA     = rd_data;
  assign bus.RD_VALID    = rd_valid;
  assign bus.FULL        = full;
  assign bus.EMPTY       = empty;
  assign bus.OVERFLOW    = overflow;
  assign bus.ERR_TIMEOUT = err_timeout;
  assign bus.READY       = ready;
  assign bus.CMD_OUT     = cmd;
  assign bus.A_OUT_BANK  = addr[23:22];
  assign bus.A_OUT_ROW   = addr[21:9];
  assign bus.A_OUT_COL   = addr[8:0];
  assign bus.D_OUT       = d_out;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Bench for sdram_scheduler: SDRAM responder, queue model
// of the circular buffer, directed scenarios.
module tb_sdram_scheduler;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #10 clk = ~clk;

  sdram_scheduler_if bus ();

  sdram_scheduler #(
    .DEPTH_WORDS  (DEPTH),
    .START_TIMEOUT(16),
    .INIT_IDLE    (2)
  ) dut (
    .CLK_48MHZ(clk),
    .RESET    (rst),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // SDRAM responder
  logic        m_status  = 1'b0;
  logic        init_busy = 1'b0;
  logic [15:0] m_data    = 16'h0;
  bit          mute      = 1'b0;
  int          busy_len  = 12;
  logic [15:0] mem [int];
  int          mst = 0;
  int          mcnt = 0;
  int          ma = 0;
  bit          mw = 1'b0;
  logic [15:0] md = 16'h0;

  assign bus.SDRAM_STATUS  = m_status | init_busy;
  assign bus.SDRAM_DATA_IN = m_data;

  wire [23:0] dut_a = {bus.A_OUT_BANK,
                       bus.A_OUT_ROW,
                       bus.A_OUT_COL};

  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      mst = 0;
      m_status = 1'b0;
    end else begin
      case (mst)
        0: if (bus.CMD_OUT != 2'd0 && !mute) begin
          ma  = int'(dut_a);
          mw  = (bus.CMD_OUT == 2'd2);
          md  = bus.D_OUT;
          mst = 1;
        end
        1: begin
          m_status = 1'b1;
          mcnt = busy_len - 1;
          mst = 2;
        end
        2: if (mcnt == 0) begin
          m_status = 1'b0;
          if (mw) mem[ma] = md;
          else m_data = mem.exists(ma) ? mem[ma] : 16'h0;
          mst = 3;
        end else begin
          mcnt--;
        end
        default: mst = 0;
      endcase
    end
  end

  // buffer model: FIFO of stored words + expected pointers
  typedef struct {
    bit          w;
    logic [23:0] a;
  } grant_t;

  logic [15:0] mq[$];
  grant_t      glog[$];
  int          m_wi = 0;
  int          m_ri = 0;
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;
  logic [15:0] m_last_rd = 16'h0;
  logic [15:0] pend_wdata = 16'h0;
  logic [1:0]  prev_cmd = 2'd0;
  logic        prev_ack = 1'b0;
  logic        prev_vld = 1'b0;
  logic [23:0] cur_a = 24'h0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_wi = 0;
      m_ri = 0;
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_last_rd = 16'h0;
      prev_cmd = 2'd0;
      prev_ack = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (!bus.READY)
        chk("cmd_before_ready", 32'(bus.CMD_OUT), 0);
      if (bus.CMD_OUT != 2'd0 && prev_cmd == 2'd0) begin
        glog.push_back('{bus.CMD_OUT == 2'd2, dut_a});
        cur_a = dut_a;
        if (bus.CMD_OUT == 2'd2) begin
          chk("wr_addr", 32'(dut_a), 32'(m_wi));
          chk("wr_dout", 32'(bus.D_OUT),
              32'(pend_wdata));
        end else begin
          chk("rd_addr", 32'(dut_a), 32'(m_ri));
          chk("rd_nonempty", 32'(mq.size() != 0), 1);
        end
      end else if (bus.CMD_OUT != 2'd0) begin
        chk("cmd_held", 32'(bus.CMD_OUT),
            32'(prev_cmd));
        chk("addr_held", 32'(dut_a), 32'(cur_a));
      end
      if (bus.WR_ACK) begin
        chk("ack_pulse", 32'(prev_ack), 0);
        if (mute) begin
          m_err = 1'b1;
          chk("wr_drop", 32'(bus.WR_DROP), 0);
        end else if (mq.size() == DEPTH) begin
          m_ovf = 1'b1;
          chk("wr_drop", 32'(bus.WR_DROP), 1);
        end else begin
          mq.push_back(pend_wdata);
          m_wi = (m_wi + 1) % DEPTH;
          chk("wr_drop", 32'(bus.WR_DROP), 0);
        end
      end else begin
        chk("drop_alone", 32'(bus.WR_DROP), 0);
      end
      if (bus.RD_VALID) begin
        chk("vld_pulse", 32'(prev_vld), 0);
        if (mute) begin
          m_err = 1'b1;
        end else if (mq.size() != 0) begin
          m_last_rd = mq.pop_front();
          m_ri = (m_ri + 1) % DEPTH;
        end
        chk("rd_data", 32'(bus.RD_DATA),
            32'(m_last_rd));
      end
      if (bus.READY) begin
        chk("full", 32'(bus.FULL),
            32'(mq.size() == DEPTH));
        chk("empty", 32'(bus.EMPTY),
            32'(mq.size() == 0));
        chk("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
        chk("err_timeout", 32'(bus.ERR_TIMEOUT),
            32'(m_err));
      end
      prev_cmd = bus.CMD_OUT;
      prev_ack = bus.WR_ACK;
      prev_vld = bus.RD_VALID;
    end
  end

  task automatic do_write(input  logic [15:0] d,
                          output logic drop,
                          output int   c2);
    bit got = 1'b0;
    pend_wdata = d;
    bus.WR_DATA = d;
    bus.WR_REQ = 1'b1;
    drop = 1'b0;
    c2 = 0;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      if (bus.CMD_OUT == 2'd2) c2++;
      if (bus.WR_ACK) begin
        got = 1'b1;
        drop = bus.WR_DROP;
      end
    end
    bus.WR_REQ = 1'b0;
    if (!got) bound_fail("wr_ack_wait");
  endtask

  task automatic do_read(output logic [15:0] d,
                         output int c1);
    bit got = 1'b0;
    bus.RD_REQ = 1'b1;
    d = 16'h0;
    c1 = 0;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      if (bus.CMD_OUT == 2'd1) c1++;
      if (bus.RD_VALID) begin
        got = 1'b1;
        d = bus.RD_DATA;
      end
    end
    bus.RD_REQ = 1'b0;
    if (!got) bound_fail("rd_valid_wait");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        drop;
    logic [15:0] d;
    logic [15:0] r0;
    logic [15:0] r1;
    int          c;
    int          cw;
    int          cr;
    int          gs;
    bit          seen;
    bus.WR_REQ  = 1'b0;
    bus.WR_DATA = 16'h0;
    bus.RD_REQ  = 1'b0;
    init_busy   = 1'b1;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(bus.CMD_OUT), 0);
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_full", 32'(bus.FULL), 0);
    chk("rst_ovf", 32'(bus.OVERFLOW), 0);
    chk("rst_err", 32'(bus.ERR_TIMEOUT), 0);
    chk("rst_ready", 32'(bus.READY), 0);
    chk("rst_rd_data", 32'(bus.RD_DATA), 0);
    chk("rst_pulses", 32'({bus.WR_ACK, bus.WR_DROP,
                           bus.RD_VALID}), 0);
    chk("rst_addr", 32'(dut_a), 0);
    chk("rst_dout", 32'(bus.D_OUT), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("ready_while_busy", 32'(bus.READY), 0);
    init_busy = 1'b0;
    @(negedge clk);
    chk("ready_after_1", 32'(bus.READY), 0);
    @(negedge clk);
    chk("ready_after_2", 32'(bus.READY), 1);

    do_write(16'hBEEF, drop, c);
    chk("beef_drop", 32'(drop), 0);
    chk("beef_cmd2_cycles", 32'(c), 2);
    chk("beef_addr", 32'(glog[glog.size()-1].a), 0);
    chk("beef_not_empty", 32'(bus.EMPTY), 0);
    do_read(d, c);
    chk("beef_rd", 32'(d), 32'hBEEF);
    chk("beef_cmd1_cycles", 32'(c), 2);
    chk("beef_empty", 32'(bus.EMPTY), 1);

    do_write(16'h1111, drop, c);
    do_write(16'h2222, drop, c);
    do_read(d, c);
    chk("pre_rd", 32'(d), 32'h1111);

    gs = glog.size();
    fork
      begin
        do_write(16'h3333, drop, cw);
        do_write(16'h4444, drop, cw);
      end
      begin
        do_read(r0, cr);
        do_read(r1, cr);
      end
    join
    chk("rr_count", 32'(glog.size() - gs), 4);
    if (glog.size() - gs >= 4) begin
      chk("rr_order", {28'h0, 1'(glog[gs].w),
          1'(glog[gs+1].w), 1'(glog[gs+2].w),
          1'(glog[gs+3].w)}, 32'b1010);
      chk("wr_ptr_wrap", 32'(glog[gs+2].a), 0);
    end
    chk("rr_rd0", 32'(r0), 32'h2222);
    chk("rr_rd1", 32'(r1), 32'h3333);
    do_read(d, c);
    chk("drain_rd", 32'(d), 32'h4444);

    for (int i = 0; i < 5; i++) begin
      do_write(16'hA000 + 16'(i), drop, c);
      chk("fill_drop", 32'(drop), 32'(i == 4));
      if (i == 4)
        chk("drop_no_cmd", 32'(c), 0);
    end
    chk("fill_full", 32'(bus.FULL), 1);
    chk("fill_ovf", 32'(bus.OVERFLOW), 1);
    for (int i = 0; i < 4; i++) begin
      do_read(d, c);
      chk("fill_rd", 32'(d), 32'hA000 + 32'(i));
    end
    chk("fill_empty", 32'(bus.EMPTY), 1);

    mute = 1'b1;
    do_write(16'h5555, drop, c);
    chk("tout_drop", 32'(drop), 0);
    chk("tout_cmd2_cycles", 32'(c), 16);
    chk("tout_err", 32'(bus.ERR_TIMEOUT), 1);
    chk("tout_empty", 32'(bus.EMPTY), 1);
    @(negedge clk);
    mute = 1'b0;

    // abort while a command is being presented
    mute = 1'b1;
    pend_wdata = 16'h6666;
    bus.WR_DATA = 16'h6666;
    bus.WR_REQ = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.CMD_OUT == 2'd2);
    end
    if (!seen) bound_fail("issue_wait");
    rst = 1'b1;
    #1;
    chk("rst_issue_cmd", 32'(bus.CMD_OUT), 0);
    chk("rst_issue_ready", 32'(bus.READY), 0);
    bus.WR_REQ = 1'b0;
    mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_issue_err", 32'(bus.ERR_TIMEOUT), 0);
    chk("rst_issue_ovf", 32'(bus.OVERFLOW), 0);
    rst = 1'b0;

    // abort while the controller is busy
    pend_wdata = 16'h6767;
    bus.WR_DATA = 16'h6767;
    bus.WR_REQ = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = m_status;
    end
    if (!seen) bound_fail("busy_wait");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_cmd", 32'(bus.CMD_OUT), 0);
    chk("rst_busy_empty", 32'(bus.EMPTY), 1);
    bus.WR_REQ = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_write(16'h7777, drop, c);
    chk("post_rst_addr", 32'(glog[glog.size()-1].a), 0);
    do_read(d, c);
    chk("post_rst_rd", 32'(d), 32'h7777);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
